// File: rtl/data_mem_access_if.sv
// Bus bundle for the load/store access unit: core-side request and response
// channels plus the word-organised data memory port.
//
// Handshake: a channel transfers on a rising clk edge where valid && ready are
// both high. The producer holds valid and its payload stable until that edge.
// ready may depend on state but never on valid of the same channel.

`ifndef DATA_MEM_DEPTH
`define DATA_MEM_DEPTH 8
`endif

interface data_mem_access_if #(
    parameter int DEPTH = `DATA_MEM_DEPTH
);
    // request channel (core -> unit)
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    // response channel (unit -> core)
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    // data memory port
    logic [DEPTH-1:0] mem_a;
    logic [31:0]      mem_d;
    logic             mem_we;
    logic [31:0]      mem_spo;

    // unit side
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_spo,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_a, mem_d, mem_we
    );

    // core / memory side
    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_spo,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_a, mem_d, mem_we
    );
endinterface

// File: rtl/data_mem_access.sv
// LA32R load/store access unit. One request at a time: alignment check,
// word read, optional read-modify-write for byte/halfword stores, and an
// extended load result returned on the response channel.

`ifndef DATA_MEM_DEPTH
`define DATA_MEM_DEPTH 8
`endif

module data_mem_access #(
    parameter int DEPTH = `DATA_MEM_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_access_if.slave bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] OP_LD_B  = 3'd0;
    localparam logic [2:0] OP_LD_H  = 3'd1;
    localparam logic [2:0] OP_LD_W  = 3'd2;
    localparam logic [2:0] OP_ST_B  = 3'd3;
    localparam logic [2:0] OP_ST_H  = 3'd4;
    localparam logic [2:0] OP_ST_W  = 3'd5;
    localparam logic [2:0] OP_LD_BU = 3'd6;
    localparam logic [2:0] OP_LD_HU = 3'd7;

    state_t           state;
    state_t           state_next;

    logic [2:0]       op_q;
    logic [1:0]       lane_q;
    logic [DEPTH-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [31:0]      merge_q;
    logic [31:0]      rsp_data_q;
    logic             rsp_err_q;

    logic             accept;
    logic             req_misaligned;
    logic             op_is_load;
    logic             op_is_sub_store;
    logic [4:0]       lane_shift;
    logic [31:0]      lane_data;
    logic [31:0]      load_value;
    logic [31:0]      lane_mask;
    logic [31:0]      lane_insert;
    logic [31:0]      merged_word;

    // Address bits above the word index wrap and are deliberately ignored.
    logic             unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:DEPTH+2];

    assign accept    = bus.req_valid && (state == IDLE);
    assign dbg_state = state;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;

    // Classify the incoming request and the latched op.
    always_comb begin
        req_misaligned = 1'b0;
        case (bus.req_op)
            OP_LD_H, OP_LD_HU, OP_ST_H: req_misaligned = bus.req_addr[0];
            OP_LD_W, OP_ST_W:           req_misaligned = (bus.req_addr[1:0] != 2'b00);
            default:                    req_misaligned = 1'b0;
        endcase
        op_is_load      = !(op_q inside {OP_ST_B, OP_ST_H, OP_ST_W});
        op_is_sub_store = (op_q == OP_ST_B) || (op_q == OP_ST_H);
    end

    // Lane extraction/extension for loads and lane replacement for sub-word stores.
    always_comb begin
        lane_shift = {lane_q, 3'b000};
        lane_data  = bus.mem_spo >> lane_shift;
        case (op_q)
            OP_LD_B:  load_value = {{24{lane_data[7]}}, lane_data[7:0]};
            OP_LD_BU: load_value = {24'd0, lane_data[7:0]};
            OP_LD_H:  load_value = {{16{lane_data[15]}}, lane_data[15:0]};
            OP_LD_HU: load_value = {16'd0, lane_data[15:0]};
            default:  load_value = bus.mem_spo;
        endcase
        if (op_q == OP_ST_H) begin
            lane_mask   = 32'h0000_FFFF << lane_shift;
            lane_insert = {16'd0, wdata_q[15:0]} << lane_shift;
        end else begin
            lane_mask   = 32'h0000_00FF << lane_shift;
            lane_insert = {24'd0, wdata_q[7:0]} << lane_shift;
        end
        merged_word = (merge_q & ~lane_mask) | lane_insert;
    end

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory/handshake outputs.
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_d     = 32'd0;
        bus.mem_a     = idx_q;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.mem_a     = '0;
                if (accept) begin
                    state_next = req_misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (op_q == OP_ST_W) begin
                    bus.mem_we = 1'b1;
                    bus.mem_d  = wdata_q;
                    state_next = RESP;
                end else if (op_is_sub_store) begin
                    state_next = MERGE;
                end else begin
                    state_next = RESP;
                end
            end
            MERGE: begin
                bus.mem_we = 1'b1;
                bus.mem_d  = merged_word;
                state_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latches, merge word and registered response payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= 3'd0;
            lane_q     <= 2'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            merge_q    <= 32'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= bus.req_op;
                lane_q     <= bus.req_addr[1:0];
                idx_q      <= bus.req_addr[DEPTH+1:2];
                wdata_q    <= bus.req_wdata;
                rsp_data_q <= 32'd0;
                rsp_err_q  <= req_misaligned;
            end
            if (state == ACCESS) begin
                if (op_is_load) begin
                    rsp_data_q <= load_value;
                end
                if (op_is_sub_store) begin
                    merge_q <= bus.mem_spo;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: directed cases followed by random
// requests, compared against a word-array reference model.

module tb_data_mem_access;

    localparam int DEPTH = 8;
    localparam int NW    = 16;   // words actually exercised

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    data_mem_access_if #(.DEPTH(DEPTH)) bus ();

    data_mem_access #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // data memory: asynchronous read, synchronous write
    logic [31:0] mem [0:(2**DEPTH)-1];
    assign bus.mem_spo = mem[bus.mem_a];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_a] <= bus.mem_d;

    // write-port monitor
    int          we_total = 0;
    int          dz_viol  = 0;
    logic [31:0] last_we_d = 32'd0;
    always @(negedge clk) begin
        if (bus.mem_we) begin
            we_total  = we_total + 1;
            last_we_d = bus.mem_d;
        end else if (bus.mem_d !== 32'd0) begin
            dz_viol = dz_viol + 1;
        end
    end

    // scoreboard / reference model state
    logic [31:0] ref_mem [0:(2**DEPTH)-1];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] last_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: what a request should do, from the access rules alone.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output int lat, output int wes);
        int          idx;
        int          lane;
        logic [31:0] w;
        logic [31:0] v;
        idx  = int'((addr >> 2) % (2**DEPTH));
        lane = int'(addr % 4);
        w    = ref_mem[idx];
        v    = 32'd0;
        err  = ((op == 3'd1 || op == 3'd4 || op == 3'd7) && (addr % 2 != 0)) ||
               ((op == 3'd2 || op == 3'd5) && lane != 0);
        lat  = err ? 1 : 2;
        wes  = 0;
        if (!err) begin
            case (op)
                3'd0, 3'd6: begin
                    v = (w >> (8 * lane)) & 32'd255;
                    if (op == 3'd0 && v > 32'd127) v = v + 32'hFFFF_FF00;
                end
                3'd1, 3'd7: begin
                    v = (w >> (8 * lane)) & 32'd65535;
                    if (op == 3'd1 && v > 32'd32767) v = v + 32'hFFFF_0000;
                end
                3'd2: v = w;
                3'd3: begin
                    ref_mem[idx] = (w & ~(32'hFF << (8 * lane))) | ((wdata & 32'hFF) << (8 * lane));
                    lat = 3; wes = 1;
                end
                3'd4: begin
                    ref_mem[idx] = (w & ~(32'hFFFF << (8 * lane))) | ((wdata & 32'hFFFF) << (8 * lane));
                    lat = 3; wes = 1;
                end
                default: begin
                    ref_mem[idx] = wdata;
                    wes = 1;
                end
            endcase
        end
        exp_q.push_back(v);
    endtask

    // Driver: one full request/response transaction, with optional back-pressure.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int bp);
        logic        err_e;
        int          lat_e, we_e, we0, lat, idx;
        logic [31:0] data_e;
        model(op, addr, wdata, err_e, lat_e, we_e);
        data_e = exp_q.pop_front();
        idx    = int'((addr >> 2) % (2**DEPTH));
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        we0 = we_total;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom_range(0, 7));
        bus.req_addr  = $urandom();
        bus.req_wdata = $urandom();
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'(lat_e));
        check("rsp_err", 32'(bus.rsp_err), 32'(err_e));
        check("rsp_data", bus.rsp_data, data_e);
        last_data = bus.rsp_data;
        for (int i = 0; i < bp; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 3'd5;
            bus.req_addr  = 32'h0;
            bus.req_wdata = 32'hBAD0_BAD0;
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_data", bus.rsp_data, data_e);
            check("bp_rsp_err", 32'(bus.rsp_err), 32'(err_e));
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("we_count", 32'(we_total - we0), 32'(we_e));
        if (we_e != 0) check("we_data", last_we_d, ref_mem[idx]);
        check("mem_word", mem[idx], ref_mem[idx]);
        @(negedge clk);
        check("idle_after", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_a"}, 32'(bus.mem_a), 32'd0);
        check({tag, "_mem_d"}, bus.mem_d, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // directed and random stimulus
    initial begin
        logic [31:0] w;
        int          idx;
        int          lane;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        last_data     = 32'd0;

        // reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // preload exercised words through word stores
        for (int i = 0; i < NW; i++) begin
            if (i == 1)      w = 32'h8899_AABB;
            else if (i == 2) w = 32'h1122_3344;
            else             w = $urandom();
            do_req(3'd5, 32'(i * 4), w, 0);
        end

        // byte loads with sign / zero extension
        do_req(3'd0, 32'h5, 32'h0, 0);
        check("tp_ld_b", last_data, 32'hFFFF_FFAA);
        do_req(3'd6, 32'h5, 32'h0, 0);
        check("tp_ld_bu", last_data, 32'h0000_00AA);

        // halfword store into the upper half of word 2
        do_req(3'd4, 32'hA, 32'hDEAD_BEEF, 0);
        check("tp_st_h_we_d", last_we_d, 32'hBEEF_3344);
        do_req(3'd2, 32'h8, 32'h0, 0);
        check("tp_st_h_word", last_data, 32'hBEEF_3344);

        // word store then read back
        do_req(3'd5, 32'hC, 32'hCAFE_F00D, 0);
        do_req(3'd2, 32'hC, 32'h0, 0);
        check("tp_st_w_word", last_data, 32'hCAFE_F00D);

        // misaligned requests
        do_req(3'd2, 32'h6, 32'h0, 0);
        do_req(3'd4, 32'h3, 32'h1234_5678, 0);
        check("tp_mis_word0", mem[0], ref_mem[0]);

        // back-pressure on a halfword load
        do_req(3'd1, 32'h6, 32'h0, 5);
        check("tp_bp_ld_h", last_data, 32'hFFFF_8899);
        check("tp_bp_word0", mem[0], ref_mem[0]);

        // reset while a byte store sits in MERGE
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd3;
        bus.req_addr  = 32'h11;
        bus.req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_in_merge", 32'(dbg_state), 32'd2);
        check("abort_we_before", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        check("abort_word", mem[4], ref_mem[4]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
        end

        // random traffic across ops, lanes, words and wrapped upper bits
        for (int n = 0; n < 80; n++) begin
            idx  = $urandom_range(0, NW - 1);
            lane = $urandom_range(0, 3);
            do_req(3'($urandom_range(0, 7)),
                   ($urandom() & 32'hFFFF_FC00) | 32'(idx * 4) | 32'(lane),
                   $urandom(), $urandom_range(0, 2));
        end

        // whole exercised region must match the model
        for (int i = 0; i < NW; i++) check("final_mem", mem[i], ref_mem[i]);
        check("mem_d_zero_when_idle", 32'(dz_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
# data_mem_access

Load/store access unit between the core's memory stage and the word-organised, asynchronous-read, synchronous-write data memory. It accepts one byte-addressed LA32R load/store request at a time over a valid/ready handshake and performs alignment checks. It implements sub-word stores as a read-modify-write of the containing word, and returns sign- or zero-extended load data over a second valid/ready handshake.

## Interface
- `DEPTH`, default `` `DATA_MEM_DEPTH ``: data memory word-address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_op` in 3: 0 LD_B, 1 LD_H, 2 LD_W, 3 ST_B, 4 ST_H, 5 ST_W, 6 LD_BU, 7 LD_HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; only the low byte or halfword is used for ST_B/ST_H.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 32: load result, extended as the op requires; 0 for stores.
- `rsp_err` out 1: request was misaligned and was not performed.
- `mem_a` out DEPTH: data memory word address.
- `mem_d` out 32: data memory write data.
- `mem_we` out 1: data memory write enable.
- `mem_spo` in 32: data memory asynchronous read data.

## Operation
- **States:** IDLE, ACCESS, MERGE, RESP.
- **Request acceptance:** `req_ready` = (state == IDLE). A request is accepted on a rising edge with `req_valid && req_ready`. At acceptance, op, addr and wdata are latched.
- **Alignment:**
  - Misaligned means H-type ops (LD_H, LD_HU, ST_H) with addr[0]=1, or W-type ops with addr[1:0]≠0.
  - A misaligned request goes IDLE→RESP with `rsp_err`=1 and `rsp_data`=0.
  - No memory write ever occurs for a misaligned request.
- **Addressing:** word index = latched addr[DEPTH+1:2]; upper address bits are ignored (wrap). Byte lane = addr[1:0], little-endian: lane 0 = bits 7:0.
- **ACCESS:** `mem_a` = word index.
  - Loads: select the lane from `mem_spo` and extend it. LD_B/LD_H sign-extend; LD_BU/LD_HU zero-extend; LD_W passes through. Register the result into `rsp_data`, then go to RESP.
  - ST_W: `mem_we`=1, `mem_d`=wdata; go to RESP.
  - ST_B/ST_H: register `mem_spo` into a merge word; go to MERGE.
- **MERGE:** `mem_a` = word index, `mem_we`=1. `mem_d` = merge word with the addressed byte or halfword replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
- **RESP:** `rsp_valid`=1. `rsp_data` and `rsp_err` are held stable until `rsp_valid && rsp_ready` on an edge, then go to IDLE.
- **Outputs outside the cases above:**
  - `mem_we`=0 in IDLE and RESP.
  - `mem_a` holds the latched word index in every state except IDLE, where it is 0.
  - `mem_d`=0 whenever `mem_we`=0.

## Timing
- **Reset values:** state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mem_we`=0, `mem_a`=0, `mem_d`=0. All latches are cleared.
- **Reset mid-operation:**
  - Reset in ACCESS or MERGE returns to IDLE immediately.
  - Any write not yet clocked is abandoned, so `mem_we` drops asynchronously.
  - No response is produced for the aborted request.
- **Latency** (accept edge → first cycle with `rsp_valid` high):
  - Misaligned request: 1 edge.
  - Load or ST_W: 2 edges.
  - ST_B/ST_H: 3 edges.
- **Memory write timing:** the write commits on the edge that leaves ACCESS (ST_W) or MERGE (sub-word store).
- **Back-pressure:** holding `rsp_ready` low keeps the unit in RESP with `req_ready`=0. No new request is accepted.
- **Throughput:** the earliest next acceptance is the edge after the response handshake, because `req_ready` is not asserted in RESP. Single outstanding request.
- **Request timing:** `req_*` inputs may change freely when not accepted. `rsp_*` outputs must not change while `rsp_valid`=1 and `rsp_ready`=0.

## Test plan
- **Byte load, sign extension:** preload word 1 = 0x8899AABB; LD_B addr 0x5 → `rsp_data`=0xFFFFFFAA, `rsp_err`=0, `rsp_valid` 2 edges after accept. LD_BU addr 0x5 → 0x000000AA.
- **Halfword store:** word 2 = 0x11223344; ST_H addr 0xA, wdata 0xDEADBEEF → single `mem_we` pulse in MERGE with `mem_d`=0xBEEF3344; word 2 reads 0xBEEF3344; `rsp_valid` 3 edges after accept.
- **Word store:** ST_W addr 0xC, wdata 0xCAFEF00D → `mem_we` high exactly one cycle (ACCESS); subsequent LD_W addr 0xC returns 0xCAFEF00D.
- **Misaligned requests:** LD_W addr 0x6 and ST_H addr 0x3 → `rsp_err`=1, `rsp_data`=0, `mem_we` never asserted, memory unchanged, response 1 edge after accept.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles during RESP → `rsp_valid`, `rsp_data` and `rsp_err` stable; `req_ready`=0 throughout; a `req_valid` pulse presented meanwhile is not accepted.
- **Reset mid-operation:** assert `rst` while in MERGE of ST_B → `mem_we` drops immediately, target word unchanged, all outputs at reset values, `req_ready`=1 after reset release.
